// File: rtl/stream_pkg.sv
// Shared stream-arbitration helpers: index typedefs and the round-robin pick
// function used by every arbiter built on this package.
package stream_pkg;

  localparam int unsigned RR_MAX_REQ = 32;
  localparam int unsigned RR_IDX_W   = 5;

  typedef logic [RR_IDX_W-1:0] rr_idx_t;

  typedef struct packed {
    logic    found;
    rr_idx_t idx;
  } rr_pick_t;

  // Search ptr, ptr+1, ... mod n and return the first set request bit.
  function automatic rr_pick_t rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                       input rr_idx_t ptr,
                                       input int unsigned n);
    rr_pick_t    res;
    int unsigned cand;
    res.found = 1'b0;
    res.idx   = '0;
    for (int unsigned k = 0; k < RR_MAX_REQ; k++) begin
      cand = 32'(ptr) + k;
      if (cand >= n) begin
        cand = cand - n;
      end else begin
        cand = cand;
      end
      if ((k < n) && !res.found && req[rr_idx_t'(cand)]) begin
        res.found = 1'b1;
        res.idx   = rr_idx_t'(cand);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/stream_arb_mux_rr_arbiter.sv
// Round-robin arbiter: owns the rotating priority pointer and advances it
// past the granted input whenever a grant is consumed.
module rr_arbiter
  import stream_pkg::*;
#(
  parameter  int unsigned INPUTS = 2,
  localparam int unsigned SEL_W  = $clog2(INPUTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INPUTS-1:0] req,
  input  logic              en,
  output logic [SEL_W-1:0]  grant_idx,
  output logic              grant_valid
);

  logic [SEL_W-1:0]      rr_ptr_q;
  logic [SEL_W-1:0]      rr_ptr_d;
  logic [RR_MAX_REQ-1:0] req_ext_s;
  rr_pick_t              pick_s;

  // Winner selection from the current pointer.
  always_comb begin
    req_ext_s   = RR_MAX_REQ'(req);
    pick_s      = rr_pick(req_ext_s, rr_idx_t'(rr_ptr_q), INPUTS);
    grant_valid = pick_s.found;
    grant_idx   = SEL_W'(pick_s.idx);
  end

  // Pointer moves one past the winner only when the grant is taken.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (en && grant_valid) begin
      if (grant_idx == SEL_W'(INPUTS - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + SEL_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/stream_arb_mux.sv
// N-to-1 valid/ready merge with round-robin arbitration and a single
// full-throughput output register tagged with the source index.
module stream_arb_mux
  import stream_pkg::*;
#(
  parameter  int unsigned WIDTH  = 32,
  parameter  int unsigned INPUTS = 2,
  localparam int unsigned SEL_W  = $clog2(INPUTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in_data [INPUTS],
  input  logic [INPUTS-1:0] in_valid,
  output logic [INPUTS-1:0] in_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [SEL_W-1:0]  out_src,
  output logic              out_valid,
  input  logic              out_ready
);

  logic              load_en_s;
  logic              arb_en_s;
  logic [SEL_W-1:0]  grant_idx_s;
  logic              grant_valid_s;

  logic              out_valid_q;
  logic              out_valid_d;
  logic [WIDTH-1:0]  out_data_q;
  logic [WIDTH-1:0]  out_data_d;
  logic [SEL_W-1:0]  out_src_q;
  logic [SEL_W-1:0]  out_src_d;

  rr_arbiter #(
    .INPUTS (INPUTS)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (in_valid),
    .en          (arb_en_s),
    .grant_idx   (grant_idx_s),
    .grant_valid (grant_valid_s)
  );

  // Register accepts a new word when empty or draining this cycle; in_ready
  // is forced low during reset so nothing is consumed then lost.
  always_comb begin
    load_en_s = !out_valid_q || out_ready;
    arb_en_s  = load_en_s && rst_n;
    in_ready  = '0;
    for (int unsigned g = 0; g < INPUTS; g++) begin
      in_ready[g] = arb_en_s && grant_valid_s &&
                    (grant_idx_s == SEL_W'(g)) && in_valid[g];
    end
  end

  // Output register next state: load winner, empty out, or hold.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (load_en_s) begin
      out_valid_d = grant_valid_s;
      if (grant_valid_s) begin
        out_data_d = in_data[grant_idx_s];
        out_src_d  = grant_idx_s;
      end else begin
        out_data_d = out_data_q;
        out_src_d  = out_src_q;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
